// File: rtl/bootloader_arb_pkg.sv
// bootloader_arb_pkg: shared types and constants for the bootloader host arbiter
package bootloader_arb_pkg;
    localparam int NREQ               = 2;
    localparam int BYTE_W             = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1200000;

    typedef enum logic [1:0] {IDLE, ARM, OWNED, DRAIN} arb_state_e;
endpackage

// File: rtl/bootloader_host_arbiter.sv
// bootloader_host_arbiter: session-based two-host arbiter in front of the bootloader FSM
// Optional idle-release timer is built when ARB_TIMEOUT_EN is defined.
module bootloader_host_arbiter
    import bootloader_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          rq_start,
    input  logic [NREQ-1:0]          rq_end,
    input  logic [NREQ-1:0]          rq_in_valid,
    input  logic [NREQ*BYTE_W-1:0]   rq_in_data,
    output logic [NREQ-1:0]          rq_in_ready,
    output logic [NREQ-1:0]          rq_out_valid,
    output logic [NREQ*BYTE_W-1:0]   rq_out_data,
    input  logic [NREQ-1:0]          rq_out_ready,
    output logic [NREQ-1:0]          rq_busy,
    output logic                     bl_in_valid,
    output logic [BYTE_W-1:0]        bl_in_data,
    input  logic                     bl_in_ready,
    input  logic                     bl_out_valid,
    input  logic [BYTE_W-1:0]        bl_out_data,
    output logic                     bl_out_ready,
    input  logic                     bl_busy,
    output logic                     bl_reset,
    output logic                     owner,
    output logic                     granted
);
    arb_state_e      r_state, w_next;
    logic [NREQ-1:0] r_pending, w_owns, w_pend_eff, w_grant_mask;
    logic            r_owner, w_owner_next, r_rr_last, r_bl_reset;
    logic            w_routed, w_hs, w_timeout;

    assign w_routed = r_state == OWNED;
    assign w_owns   = (r_state == ARM || r_state == OWNED) ? (NREQ'(1) << r_owner) : '0;
    // Start/end from the current owner are FSM commands, never pending requests
    assign w_pend_eff   = (r_pending | (rq_start & ~w_owns)) & ~(rq_end & ~w_owns);
    assign w_grant_mask = (w_next == ARM) ? (NREQ'(1) << w_owner_next) : '0;
    assign w_hs = w_routed && ((rq_in_valid[r_owner] && bl_in_ready) ||
                               (bl_out_valid && rq_out_ready[r_owner]));

    always_comb begin
        w_next       = r_state;
        w_owner_next = r_owner;
        case (r_state)
            IDLE: begin
                if (|w_pend_eff) begin
                    w_next       = ARM;
                    w_owner_next = &w_pend_eff ? ~r_rr_last : w_pend_eff[1];
                end
            end
            ARM:   w_next = OWNED;
            OWNED: w_next = rq_end[r_owner]   ? (bl_busy ? DRAIN : IDLE) :
                            rq_start[r_owner] ? ARM :
                            w_timeout         ? DRAIN : OWNED;
            DRAIN: w_next = bl_busy ? DRAIN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_owner    <= 1'b0;
            r_rr_last  <= 1'b1;
            r_bl_reset <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pending  <= w_pend_eff & ~w_grant_mask;
            r_owner    <= w_owner_next;
            r_bl_reset <= w_next == ARM;
            if (r_state == ARM)
                r_rr_last <= r_owner;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] r_timer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_timer <= '0;
        else if (w_next == ARM)
            r_timer <= '0;
        else if (w_routed)
            r_timer <= w_hs ? '0 : (&r_timer ? r_timer : r_timer + 1'b1);
    end

    assign w_timeout = r_timer == TIMER_W'(TIMEOUT_CYCLES - 1);
`else
    logic w_unused_timer;
    assign w_unused_timer = ^{TIMEOUT_CYCLES, TIMER_W, w_hs};
    assign w_timeout      = 1'b0;
`endif

    // Only the owner lane is ever connected; every other lane reads busy
    assign bl_in_valid  = w_routed && rq_in_valid[r_owner];
    assign bl_in_data   = rq_in_data[BYTE_W*r_owner +: BYTE_W];
    assign rq_in_ready  = w_routed ? (w_owns & {NREQ{bl_in_ready}}) : '0;
    assign rq_out_valid = w_routed ? (w_owns & {NREQ{bl_out_valid}}) : '0;
    assign rq_out_data  = {NREQ{bl_out_data}};
    assign bl_out_ready = w_routed ? rq_out_ready[r_owner] : (r_state == DRAIN);
    assign rq_busy      = w_routed ? (~w_owns | {NREQ{bl_busy}}) : '1;
    assign bl_reset     = r_bl_reset;
    assign owner        = r_owner;
    assign granted      = r_state == ARM || r_state == OWNED;
endmodule

// File: tb/tb_bootloader_host_arbiter.sv
// tb_bootloader_host_arbiter: randomized scoreboard bench against a session-level reference model
module tb_bootloader_host_arbiter;
    localparam int TC = 16;
    localparam int FREE = 0, PULSE = 1, SESS = 2, DRN = 3;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [1:0]  rq_start, rq_end, rq_in_valid, rq_in_ready, rq_out_valid, rq_out_ready, rq_busy;
    logic [15:0] rq_in_data, rq_out_data;
    logic        bl_in_valid, bl_in_ready, bl_out_valid, bl_out_ready, bl_busy, bl_reset, owner, granted;
    logic [7:0]  bl_in_data, bl_out_data;

    bootloader_host_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .resetn(resetn), .rq_start(rq_start), .rq_end(rq_end),
        .rq_in_valid(rq_in_valid), .rq_in_data(rq_in_data), .rq_in_ready(rq_in_ready),
        .rq_out_valid(rq_out_valid), .rq_out_data(rq_out_data), .rq_out_ready(rq_out_ready),
        .rq_busy(rq_busy), .bl_in_valid(bl_in_valid), .bl_in_data(bl_in_data),
        .bl_in_ready(bl_in_ready), .bl_out_valid(bl_out_valid), .bl_out_data(bl_out_data),
        .bl_out_ready(bl_out_ready), .bl_busy(bl_busy), .bl_reset(bl_reset),
        .owner(owner), .granted(granted)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          ph, own, last, tmr, act, quiet;
    logic [1:0]  wt;
    bit          did_rst;
    logic [10:0] q_ctl[$];
    logic [7:0]  q_in[$];
    logic [8:0]  q_out[$];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    function automatic logic [10:0] actual();
        return {bl_in_valid, rq_in_ready, rq_out_valid, bl_out_ready, rq_busy, bl_reset, granted, owner};
    endfunction

    task automatic model_reset();
        ph = FREE; own = 0; last = 1; tmr = 0; wt = 2'b00;
    endtask

    // Advance the session model by one clock using the inputs the DUT just sampled
    task automatic model_step();
        logic [1:0] o, w;
        bit hs, to;
        for (int n = 0; n < 2; n++) o[n] = (ph == PULSE || ph == SESS) && own == n;
        w = wt;
        for (int n = 0; n < 2; n++) begin
            if (!o[n] && rq_start[n]) w[n] = 1'b1;
            if (!o[n] && rq_end[n]) w[n] = 1'b0;
        end
        hs = ph == SESS && ((rq_in_valid[own] && bl_in_ready) || (bl_out_valid && rq_out_ready[own]));
        to = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to = tmr == TC - 1;
`endif
        case (ph)
            FREE: if (w != 2'b00) begin
                own = (w == 2'b11) ? 1 - last : (w[1] ? 1 : 0);
                w[own] = 1'b0; ph = PULSE; tmr = 0;
            end
            PULSE: begin last = own; ph = SESS; end
            SESS: begin
                tmr = hs ? 0 : (tmr < TC ? tmr + 1 : tmr);
                if (rq_end[own]) ph = bl_busy ? DRN : FREE;
                else if (rq_start[own]) begin ph = PULSE; tmr = 0; end
                else if (to) ph = DRN;
            end
            default: if (!bl_busy) ph = FREE;
        endcase
        wt = w;
    endtask

    function automatic logic [10:0] predict();
        logic [1:0] iv, ov, bz;
        bit r, mine;
        r = ph == SESS;
        for (int n = 0; n < 2; n++) begin
            mine  = r && own == n;
            iv[n] = mine && bl_in_ready;
            ov[n] = mine && bl_out_valid;
            bz[n] = mine ? bl_busy : 1'b1;
        end
        return {r && rq_in_valid[own], iv, ov, r ? rq_out_ready[own] : (ph == DRN), bz,
                ph == PULSE, ph == PULSE || ph == SESS, own[0]};
    endfunction

    task automatic zero_inputs();
        rq_start = 0; rq_end = 0; rq_in_valid = 0; rq_in_data = 0; rq_out_ready = 0;
        bl_in_ready = 0; bl_out_valid = 0; bl_out_data = 0; bl_busy = 0;
    endtask

    task automatic drive(input bit no_starts, input logic [1:0] force_st);
        logic [1:0] o;
        bit st, en;
        for (int n = 0; n < 2; n++) begin
            o[n] = (ph == PULSE || ph == SESS) && own == n;
            rq_in_valid[n]  = int'($urandom_range(0, 3)) < act;
            rq_out_ready[n] = $urandom_range(0, 3) != 0;
            st = force_st[n] || (!no_starts && $urandom_range(0, 29) == 0);
            en = !force_st[n] && $urandom_range(0, 24) == 0;
            if (o[n] && ph == PULSE) begin st = 0; en = 0; end
            if (!o[n] && st) en = 0;
            rq_start[n] = st;
            rq_end[n]   = en;
        end
        rq_in_data   = 16'($urandom);
        bl_in_ready  = $urandom_range(0, 3) != 0;
        bl_out_valid = int'($urandom_range(0, 3)) < act;
        bl_out_data  = 8'($urandom);
        bl_busy      = $urandom_range(0, 3) == 0;
        q_ctl.push_back(predict());
        if (ph == SESS && rq_in_valid[own] && bl_in_ready) q_in.push_back(rq_in_data[8*own +: 8]);
        if (ph == SESS && bl_out_valid) q_out.push_back({own[0], bl_out_data});
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (q_ctl.size() != 0) chk("ctl", 32'(actual()), 32'(q_ctl.pop_front()));
            if (bl_in_valid && bl_in_ready) begin
                if (q_in.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL in_extra got byte %h want none", bl_in_data);
                end else chk("in_byte", 32'(bl_in_data), 32'(q_in.pop_front()));
            end
            if (rq_out_valid != 2'b00) begin
                if (q_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_extra got valid %b want none", rq_out_valid);
                end else begin
                    logic [8:0] e;
                    e = q_out.pop_front();
                    chk("out_lane", 32'(rq_out_valid), 32'(2'b01 << e[8]));
                    chk("out_data", 32'(rq_out_data), 32'({e[7:0], e[7:0]}));
                end
            end
        end
    end

    initial begin
        zero_inputs();
        model_reset();
        act = 2; quiet = 0; did_rst = 0;
        repeat (3) @(posedge clk);
        #1 chk("reset", 32'(actual()), 32'(11'b0_00_00_0_11_000));
        resetn = 1'b1;
        drive(0, 2'b11);
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] fs;
            @(posedge clk); #1;
            if (i % 200 == 0) act = $urandom_range(0, 3);
            model_step();
            fs = 2'b00;
            if (!did_rst && ((i >= 1500 && ph == SESS && wt != 2'b00) || i == 3000)) begin
                resetn = 1'b0;
                zero_inputs();
                #1 chk("midrst", 32'(actual()), 32'(11'b0_00_00_0_11_000));
                model_reset();
                q_ctl.delete(); q_in.delete(); q_out.delete();
                did_rst = 1; quiet = 3;
                @(posedge clk); #1 resetn = 1'b1;
            end else if (!did_rst && i >= 1500 && ph == SESS) begin
                fs[1 - own] = 1'b1;
            end
            drive(quiet > 0, fs);
            if (quiet > 0) quiet--;
        end
        @(negedge clk); #1;
        chk("q_empty", 32'(q_ctl.size() + q_in.size() + q_out.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bootloader_host_arbiter.md
Name: bootloader_host_arbiter

Overview:
- Shares the single bootloader byte-stream FSM between two host transports: requester 0 is the I2C bridge, requester 1 is a second transport (e.g. UART/SPI).
- Grants are session-based. A requester's start pulse claims the bootloader, and the grant is held until that requester's end pulse, or until the idle timeout when the optional feature is compiled in.
- On every grant the block issues a one-cycle bootloader reset, then routes both byte streams to the owner only.
- It sits between the transport bridges and the bootloader FSM. The bridges' existing bootloader-side ports connect to this block unchanged.

Parameters:
- TIMEOUT_CYCLES, 1200000: cycles of no owner traffic before a forced release (100 ms at 12 MHz). Used only with ARB_TIMEOUT_EN.
- TIMER_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rq_start  in  2  per-requester session start pulse (bit n = requester n)
- rq_end  in  2  per-requester session end pulse
- rq_in_valid  in  2  host→bootloader byte valid
- rq_in_data  in  16  host→bootloader bytes ([8n+7:8n] = requester n)
- rq_in_ready  out  2  host→bootloader ready
- rq_out_valid  out  2  bootloader→host byte valid
- rq_out_data  out  16  bootloader→host bytes (both lanes carry bl_out_data)
- rq_out_ready  in  2  bootloader→host ready
- rq_busy  out  2  busy as seen by each requester
- bl_in_valid  out  1  to bootloader
- bl_in_data  out  8  to bootloader
- bl_in_ready  in  1  from bootloader
- bl_out_valid  in  1  from bootloader
- bl_out_data  in  8  from bootloader
- bl_out_ready  out  1  to bootloader
- bl_busy  in  1  bootloader busy
- bl_reset  out  1  bootloader reset pulse, registered
- owner  out  1  current or last owner index
- granted  out  1  1 while in ARM or OWNED

Behaviour:
- **Reset.** Asynchronous assert on resetn=0. State=IDLE, pending=2'b00, owner=0, granted=0, bl_reset=0, timer=0, rr_last=1.
- **Pending.**
  - pending[n] is set by rq_start[n].
  - It is cleared when requester n enters ARM, or by rq_end[n] while n does not own the bootloader.
- **IDLE.**
  - If any pending bit is set, go to ARM.
  - Owner selection: if only one bit is set, that requester wins. If both are set, the winner is the requester that is not rr_last.
  - Zero-cycle idle is allowed: a start arriving in IDLE reaches ARM on the next edge.
- **ARM (1 cycle).**
  - bl_reset=1 and granted=1.
  - Next state is OWNED, and rr_last is set to owner.
- **OWNED.** The datapath is routed combinationally to the owner:
  - bl_in_valid/bl_in_data come from the owner lane.
  - rq_in_ready[owner]=bl_in_ready.
  - rq_out_valid[owner]=bl_out_valid, and bl_out_ready=rq_out_ready[owner].
  - rq_busy[owner]=bl_busy.
- **Non-owner lanes, in every state.**
  - rq_in_ready=0, rq_out_valid=0 and rq_busy=1.
  - A blocked host therefore reads "busy" in its status byte.
- **Start from the owner while in OWNED.**
  - rq_start[owner] re-enters ARM, giving a fresh bl_reset with the same owner.
  - This is a new command inside the same session.
- **End from the owner while in OWNED.**
  - If bl_busy=0, go to IDLE.
  - If bl_busy=1, go to DRAIN.
- **DRAIN.**
  - bl_out_ready=1, and bootloader output bytes are discarded.
  - rq_*[owner] behave as non-owner.
  - Leave for IDLE when bl_busy=0.
- **Simultaneous events.**
  - rq_start[owner] together with rq_end[owner] in the same cycle: end wins.
  - rq_start from the non-owner while in OWNED or DRAIN: latched in pending and served after release.
  - The ready/valid transfer in progress on the cycle of end is completed.
- **Fairness.** Round-robin guarantees that a waiting requester is served before the previous owner regains the bootloader.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- **Defined.**
  - timer counts cycles in OWNED with no handshake on the owner lane, meaning no rq_in_valid&&rq_in_ready and no bl_out_valid&&bl_out_ready.
  - timer resets to 0 on any such handshake and on entering ARM.
  - When timer reaches TIMEOUT_CYCLES-1, go to DRAIN, regardless of bl_busy.
  - The counter saturates and does not wrap.
- **Not defined.**
  - No timer logic is built, and ownership is held until rq_end.

Decomposition:
- **Package bootloader_arb_pkg:**
  - state enum {IDLE, ARM, OWNED, DRAIN}
  - NREQ=2 and BYTE_W=8
  - default TIMEOUT_CYCLES
- **Sub-module:** none required. The optional idle timer may be a small counter module, arb_idle_timer.

Test Plan:
1. **Single requester session.**
   - Stimulus: rq_start[0] pulse, then 3 bytes 0x11/0x22/0x33 in, bl_out_valid with 0x5A, then rq_end[0].
   - Required response: bl_reset high exactly 1 cycle after start+1, the bytes reach bl_in_data in order, rq_out_data=0x5A with rq_out_valid[0], then state returns to IDLE.
2. **Simultaneous starts after reset.**
   - Stimulus: rq_start=2'b11 in the same cycle.
   - Required response: owner=0 first (rr_last=1), rq_busy[1]=1 and rq_in_ready[1]=0 throughout. After rq_end[0], a second bl_reset pulse occurs with owner=1.
3. **Re-command in session.**
   - Stimulus: rq_start[1] twice, 10 cycles apart, while owner=1.
   - Required response: two bl_reset pulses, owner stays 1, rq_busy[0]=1 throughout.
4. **End while busy.**
   - Stimulus: rq_end[0] with bl_busy=1 for 5 more cycles, with bl_out_valid pulsed.
   - Required response: DRAIN, with bl_out_ready=1 and rq_out_valid=0; IDLE on the cycle after bl_busy falls.
5. **Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16).**
   - Stimulus: owner 0 goes silent.
   - Required response: DRAIN entered 16 cycles after the last handshake. A handshake at cycle 10 restarts the count.
6. **Reset mid-operation.**
   - Stimulus: resetn low during OWNED with pending[1] set.
   - Required response: all outputs return to reset values immediately and pending is cleared.
